mem_stage_sram_param: RTL and testbench
=======================================

// Module: mem_stage_sram_param
// PURPOSE
// - Parametrised MEM pipeline stage: passes EXE->WB control/result through, and runs data-memory accesses on an external async SRAM narrower than the CPU word.
// - Each CPU word is split into DATA_W/SRAM_DW SRAM beats with programmable wait states.
// - mem_ready freezes the pipeline while an access is in flight.
// PARAMETERS
// - DATA_W       32    CPU word width; power of two, multiple of SRAM_DW
// - SRAM_DW      16    SRAM data-bus width; BEATS = DATA_W/SRAM_DW
// - SRAM_AW      18    SRAM address width
// - DEST_W       4     destination register index width
// - WAIT_CYCLES  1     extra cycles per beat (each beat lasts WAIT_CYCLES+1 cycles)
// - ADDR_BASE    1024  CPU byte address mapped to SRAM word 0
// PORTS
// - clk           in   1         clock; all state on rising edge
// - rst           in   1         synchronous, active-high reset
// - WB_EN_in      in   1         write-back enable from EXE
// - MEM_R_EN_in   in   1         load request
// - MEM_W_EN_in   in   1         store request
// - ALU_res_in    in   DATA_W    byte address / ALU result
// - Val_Rm_in     in   DATA_W    store data
// - Dest_in       in   DEST_W    destination register
// - WB_EN_out     out  1         = WB_EN_in
// - MEM_R_EN_out  out  1         = MEM_R_EN_in
// - ALU_res_out   out  DATA_W    = ALU_res_in
// - Dest_out      out  DEST_W    = Dest_in
// - MEM_data_out  out  DATA_W    registered result of the last completed load
// - FW_ALU_res    out  DATA_W    forward value: MEM_R_EN_in ? MEM_data_out : ALU_res_in
// - mem_ready     out  1         1 = stage may advance; 0 = stall pipeline
// - SRAM_DQ       inout SRAM_DW  SRAM data; driven only during write beats, else Z
// - SRAM_ADDR     out  SRAM_AW   SRAM word address
// - SRAM_UB_N, SRAM_LB_N  out 1  byte lanes; tied 0 (full-width access)
// - SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  out 1  active-low strobes
// BEHAVIOUR
// - Reset: FSM=IDLE, beat/wait counters=0, MEM_data_out=0, WE_N=CE_N=OE_N=1, SRAM_ADDR=0, DQ=Z.
// - word = (ALU_res_in-ADDR_BASE)>>log2(DATA_W/8); SRAM_ADDR = (word*BEATS+beat) truncated to SRAM_AW (wraps silently).
// - FSM IDLE -> ACCESS on (R_EN|W_EN); W_EN takes priority if both are asserted. ACCESS -> DONE after BEATS*(WAIT_CYCLES+1) cycles. DONE -> IDLE unconditionally.
// - mem_ready = (IDLE & !req) | DONE. It is combinational, so it drops in the same cycle a request appears.
// - Inputs are held stable by the frozen pipeline until mem_ready=1.
// - Beat order: beat 0 = least-significant SRAM_DW bits.
// - Read: CE_N=OE_N=0 in ACCESS. Beat data is captured into the matching slice on the last cycle of each beat. MEM_data_out updates on entry to DONE and holds until the next load completes.
// - Write: CE_N=WE_N=0 in ACCESS. DQ is driven with the beat slice of Val_Rm_in.
// - Latency (defaults): BEATS=2, WAIT=1 -> 4 ACCESS cycles + 1 DONE, so mem_ready is 0 for 4 cycles.
// - No request: 0-cycle pass-through, mem_ready=1.
// - rst asserted mid-access: abort at the next edge; SRAM contents are undefined for the partial word; all outputs return to reset values.
// CONFIGURATION
// - MEM_POSTED_WRITE_EN defined:
//   - One-entry write buffer. A write in IDLE with the buffer empty latches {addr,data} and gives mem_ready=1 in that same cycle.
//   - The buffer drains in background state WDRAIN (same beat timing as ACCESS).
//   - Any request arriving during WDRAIN sees mem_ready=0 until the drain finishes, then proceeds normally, so read-after-write ordering is preserved.
// - Undefined: writes block exactly like reads; the WDRAIN state and the buffer are absent.
// TESTING
// - Write 0xDEADBEEF @1024 -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; mem_ready 0 for 4 cycles, then 1 for 1 cycle.
// - Read @1024 after that write -> MEM_data_out=FW_ALU_res=0xDEADBEEF at DONE; R_EN=0 -> FW_ALU_res=ALU_res_in.
// - Read @1028 -> SRAM_ADDR sequence 2,3; back-to-back requests each take 5 cycles, with no extra IDLE cycle needed.
// - Params DATA_W=32, SRAM_DW=8, WAIT=0: write 0x11223344 @1024 -> SRAM[0..3]=44,33,22,11; mem_ready 0 for 4 cycles.
// - rst pulsed in cycle 2 of a write -> next cycle: WE_N=CE_N=1, DQ=Z, mem_ready=1, MEM_data_out=0.
// - MEM_POSTED_WRITE_EN: write then immediate read of same address -> write sees mem_ready=1 at once; read stalls through drain plus its own access and returns the written value.

Source files
------------

// File: rtl/mem_stage_sram_param.sv
// mem_stage_sram_param
// MEM pipeline stage. Control and ALU result pass straight through to WB, and
// loads/stores run on an external asynchronous SRAM that is narrower than the
// CPU word. Each word is moved as BEATS = DATA_W/SRAM_DW beats, with beat 0
// carrying the least-significant slice. Each beat is held for WAIT_CYCLES+1
// cycles. mem_ready freezes the pipeline while an access is in flight.
//
// The cycle in which a request first appears in IDLE already counts as the
// first access cycle: strobes and address assert combinationally from it.
// This keeps a request at BEATS*(WAIT_CYCLES+1) stall cycles plus one DONE
// cycle, and lets back-to-back requests run without a gap.
//
// Optional feature: define MEM_POSTED_WRITE_EN to add a one-entry posted
// write buffer. That build also adds the background drain state WDRAIN.
`timescale 1ns/1ps
module mem_stage_sram_param #(
  parameter int DATA_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int DEST_W      = 4,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_BASE   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               WB_EN_in,
  input  logic               MEM_R_EN_in,
  input  logic               MEM_W_EN_in,
  input  logic [DATA_W-1:0]  ALU_res_in,
  input  logic [DATA_W-1:0]  Val_Rm_in,
  input  logic [DEST_W-1:0]  Dest_in,
  output logic               WB_EN_out,
  output logic               MEM_R_EN_out,
  output logic [DATA_W-1:0]  ALU_res_out,
  output logic [DEST_W-1:0]  Dest_out,
  output logic [DATA_W-1:0]  MEM_data_out,
  output logic [DATA_W-1:0]  FW_ALU_res,
  output logic               mem_ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  localparam int BEATS   = DATA_W / SRAM_DW;
  localparam int BEAT_SH = (BEATS > 1) ? $clog2(BEATS) : 0;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAIT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int CALC_W  = ((DATA_W + BEAT_SH) > SRAM_AW) ? (DATA_W + BEAT_SH) : SRAM_AW;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);
  localparam logic [DATA_W-1:0] BASE_VAL  = DATA_W'(ADDR_BASE);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
`ifdef MEM_POSTED_WRITE_EN
  localparam logic [1:0] WDRAIN = 2'd3;
`endif

  logic [1:0]        state_reg, state_next;
  logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              op_write_reg, op_write_next;
  logic [DATA_W-1:0] mem_data_reg;

  logic              req;
  logic              start;
  logic              active;
  logic              cur_write;
  logic              write_beat;
  logic              read_beat;
  logic              beat_end;
  logic              seq_end;
  logic [DATA_W-1:0] byte_off;
  logic [SRAM_AW-1:0] in_base;
  logic [SRAM_AW-1:0] cur_base;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;
  logic [SRAM_DW-1:0] wr_slice [BEATS];
  logic [SRAM_DW-1:0] rd_slice_reg [BEATS];

`ifdef MEM_POSTED_WRITE_EN
  logic               post;
  logic               draining;
  logic [SRAM_AW-1:0] wbuf_addr_reg;
  logic [DATA_W-1:0]  wbuf_data_reg;
`endif

  // Pipeline pass-through and forwarding
  assign WB_EN_out    = WB_EN_in;
  assign MEM_R_EN_out = MEM_R_EN_in;
  assign ALU_res_out  = ALU_res_in;
  assign Dest_out     = Dest_in;
  assign MEM_data_out = mem_data_reg;
  assign FW_ALU_res   = MEM_R_EN_in ? mem_data_reg : ALU_res_in;

  assign req = MEM_R_EN_in | MEM_W_EN_in;

  // SRAM word address of beat 0: byte offset to word index, scaled by BEATS, wrapped
  assign byte_off = ALU_res_in - BASE_VAL;
  assign in_base  = SRAM_AW'(CALC_W'(byte_off >> BYTE_SH) << BEAT_SH);

  assign beat_end = (wait_cnt_reg == WAIT_LAST);
  assign seq_end  = beat_end && (beat_cnt_reg == BEAT_LAST);

  // Decode which beat sequence (if any) is running this cycle and its direction
  always_comb begin
    start     = 1'b0;
    active    = 1'b0;
    cur_write = op_write_reg;
    cur_base  = in_base;
    wr_word   = Val_Rm_in;
`ifdef MEM_POSTED_WRITE_EN
    post     = (state_reg == IDLE) && MEM_W_EN_in;
    draining = (state_reg == WDRAIN);
    start    = (state_reg == IDLE) && MEM_R_EN_in && !MEM_W_EN_in;
    active   = start || (state_reg == ACCESS) || draining;
    if (state_reg == IDLE) begin
      cur_write = 1'b0;
    end else if (draining) begin
      cur_write = 1'b1;
      cur_base  = wbuf_addr_reg;
      wr_word   = wbuf_data_reg;
    end
`else
    start  = (state_reg == IDLE) && req;
    active = start || (state_reg == ACCESS);
    if (state_reg == IDLE) begin
      cur_write = MEM_W_EN_in;
    end
`endif
  end

  assign write_beat = active && cur_write;
  assign read_beat  = active && !cur_write;

  // Stall whenever a request is pending and no completed result is presented
  always_comb begin
    mem_ready = ((state_reg == IDLE) && !req) || (state_reg == DONE);
`ifdef MEM_POSTED_WRITE_EN
    if (post || (draining && !req)) begin
      mem_ready = 1'b1;
    end
`endif
  end

  // Beat/wait counters step through the sequence and rewind at its end
  always_comb begin
    beat_cnt_next = '0;
    wait_cnt_next = '0;
    if (active && !seq_end) begin
      if (beat_end) begin
        beat_cnt_next = beat_cnt_reg + 1'b1;
      end else begin
        beat_cnt_next = beat_cnt_reg;
        wait_cnt_next = wait_cnt_reg + 1'b1;
      end
    end
  end

  // Next-state logic; a write wins over a read when both are requested
  always_comb begin
    state_next    = state_reg;
    op_write_next = op_write_reg;
    case (state_reg)
      IDLE: begin
`ifdef MEM_POSTED_WRITE_EN
        if (post) begin
          state_next = WDRAIN;
        end else
`endif
        if (start) begin
          op_write_next = MEM_W_EN_in;
          state_next    = seq_end ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (seq_end) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
`ifdef MEM_POSTED_WRITE_EN
      WDRAIN: begin
        if (seq_end) begin
          state_next = IDLE;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      op_write_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      op_write_reg <= op_write_next;
    end
  end

`ifdef MEM_POSTED_WRITE_EN
  // Write buffer latches address and data as the write is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      wbuf_addr_reg <= '0;
      wbuf_data_reg <= '0;
    end else if (post) begin
      wbuf_addr_reg <= in_base;
      wbuf_data_reg <= Val_Rm_in;
    end
  end
`endif

  // Per-beat slicing of write data and read-data assembly
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      assign wr_slice[gi] = wr_word[gi*SRAM_DW +: SRAM_DW];
      // The beat currently on the bus is taken live so the last beat needs no extra cycle
      assign rd_word[gi*SRAM_DW +: SRAM_DW] =
        (beat_cnt_reg == BEAT_W'(gi)) ? SRAM_DQ : rd_slice_reg[gi];

      // Capture this slice on the final cycle of its beat
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_slice_reg[gi] <= '0;
        end else if (read_beat && beat_end && (beat_cnt_reg == BEAT_W'(gi))) begin
          rd_slice_reg[gi] <= SRAM_DQ;
        end
      end
    end
  endgenerate

  // Load result register updates as the read sequence completes (visible in DONE)
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_data_reg <= '0;
    end else if (read_beat && seq_end) begin
      mem_data_reg <= rd_word;
    end
  end

  // SRAM pins
  assign SRAM_ADDR = active ? (cur_base + SRAM_AW'(beat_cnt_reg)) : '0;
  assign SRAM_CE_N = !active;
  assign SRAM_OE_N = !read_beat;
  assign SRAM_WE_N = !write_beat;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = write_beat ? wr_slice[beat_cnt_reg] : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_mem_stage_sram_param.sv
// Testbench for mem_stage_sram_param: a default-parameter instance driven by
// directed and random transactions against a word-level reference model, and
// a byte-wide zero-wait instance for a short directed run.
`timescale 1ns/1ps
module tb_mem_stage_sram_param;

  localparam int DATA_W      = 32;
  localparam int SRAM_DW     = 16;
  localparam int SRAM_AW     = 18;
  localparam int DEST_W      = 4;
  localparam int WAIT_CYCLES = 1;
  localparam int ADDR_BASE   = 1024;
  localparam int BEATS       = DATA_W / SRAM_DW;
  localparam int LAT         = BEATS * (WAIT_CYCLES + 1);
  localparam int KEYS        = (1 << SRAM_AW) / BEATS;
  localparam int AW8         = 10;
`ifdef MEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance signals
  logic              wb_en_in = 0, mem_r_en_in = 0, mem_w_en_in = 0;
  logic [DATA_W-1:0] alu_res_in = 0, val_rm_in = 0;
  logic [DEST_W-1:0] dest_in = 0;
  logic              wb_en_out, mem_r_en_out, mem_ready;
  logic [DATA_W-1:0] alu_res_out, mem_data_out, fw_alu_res;
  logic [DEST_W-1:0] dest_out;
  wire  [SRAM_DW-1:0] sram_dq;
  logic [SRAM_AW-1:0] sram_addr;
  logic sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;

  // Byte-wide instance signals
  logic        r8 = 0, w8 = 0;
  logic [31:0] alu8 = 0, val8 = 0;
  logic        wb8_out, r8_out, ready8;
  logic [31:0] alu8_out, data8_out, fw8_out;
  logic [3:0]  dest8_out;
  wire  [7:0]  dq8;
  logic [AW8-1:0] addr8;
  logic ub8_n, lb8_n, we8_n, ce8_n, oe8_n;

  mem_stage_sram_param #(
    .DATA_W(DATA_W), .SRAM_DW(SRAM_DW), .SRAM_AW(SRAM_AW), .DEST_W(DEST_W),
    .WAIT_CYCLES(WAIT_CYCLES), .ADDR_BASE(ADDR_BASE)
  ) u_dut (
    .clk(clk), .rst(rst),
    .WB_EN_in(wb_en_in), .MEM_R_EN_in(mem_r_en_in), .MEM_W_EN_in(mem_w_en_in),
    .ALU_res_in(alu_res_in), .Val_Rm_in(val_rm_in), .Dest_in(dest_in),
    .WB_EN_out(wb_en_out), .MEM_R_EN_out(mem_r_en_out), .ALU_res_out(alu_res_out),
    .Dest_out(dest_out), .MEM_data_out(mem_data_out), .FW_ALU_res(fw_alu_res),
    .mem_ready(mem_ready), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
    .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n), .SRAM_WE_N(sram_we_n),
    .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n)
  );

  mem_stage_sram_param #(
    .DATA_W(32), .SRAM_DW(8), .SRAM_AW(AW8), .DEST_W(4),
    .WAIT_CYCLES(0), .ADDR_BASE(1024)
  ) u_dut8 (
    .clk(clk), .rst(rst),
    .WB_EN_in(1'b0), .MEM_R_EN_in(r8), .MEM_W_EN_in(w8),
    .ALU_res_in(alu8), .Val_Rm_in(val8), .Dest_in(4'd0),
    .WB_EN_out(wb8_out), .MEM_R_EN_out(r8_out), .ALU_res_out(alu8_out),
    .Dest_out(dest8_out), .MEM_data_out(data8_out), .FW_ALU_res(fw8_out),
    .mem_ready(ready8), .SRAM_DQ(dq8), .SRAM_ADDR(addr8),
    .SRAM_UB_N(ub8_n), .SRAM_LB_N(lb8_n), .SRAM_WE_N(we8_n),
    .SRAM_CE_N(ce8_n), .SRAM_OE_N(oe8_n)
  );

  // Asynchronous SRAM models: drive on output enable, store while write enable is low
  logic [SRAM_DW-1:0] sram_mem [0:(1<<SRAM_AW)-1];
  logic [7:0]         sram8_mem [0:(1<<AW8)-1];
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 'z;
  assign dq8     = (!ce8_n && !oe8_n && we8_n) ? sram8_mem[addr8] : 'z;
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_dq;
    if (!ce8_n && !we8_n) sram8_mem[addr8] <= dq8;
  end

  // Reference model state
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] last_load = 0;
  bit          load_known = 1'b1;
  int          drain_rem = 0;
  int          op_no = 0;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned key_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(ADDR_BASE);
    return (off / 4) % KEYS;
  endfunction

  function automatic logic [31:0] pick_addr();
    int idx;
    idx = $urandom_range(0, 19);
    if (idx < 16) return 32'(ADDR_BASE + 4 * idx);
    else if (idx == 16) return 32'(ADDR_BASE - 4);
    else if (idx == 17) return 32'(ADDR_BASE + 4 * (KEYS - 1));
    else if (idx == 18) return 32'(ADDR_BASE + 4 * KEYS);
    else return 32'(ADDR_BASE - 8);
  endfunction

  // One pipeline transaction on the main instance; starts and ends just after a rising edge
  task automatic do_op(input bit r, input bit w, input logic [31:0] addr, input logic [31:0] wdata);
    int exp_stall, own_acc, stall, k;
    logic [31:0] off;
    logic [DEST_W-1:0] dest;
    logic wb;
    longint exp_addr;
    int unsigned key;
    dest = DEST_W'($urandom);
    wb   = 1'($urandom);
    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    alu_res_in = addr; val_rm_in = wdata; dest_in = dest;
    off = addr - 32'(ADDR_BASE);
    key = key_of(addr);
    if (!(r || w)) begin
      exp_stall = 0; own_acc = 0;
    end else if (w && POSTED) begin
      exp_stall = drain_rem; own_acc = 0;
    end else begin
      exp_stall = drain_rem + LAT; own_acc = LAT;
    end
    stall = 0;
    forever begin
      @(negedge clk);
      if (mem_ready === 1'b1) break;
      k = stall - (exp_stall - own_acc);
      if (k >= 0 && k < own_acc) begin
        exp_addr = (longint'(off / 4) * BEATS + k / (WAIT_CYCLES + 1)) % (longint'(1) << SRAM_AW);
        check_val("acc_pins", {sram_ce_n, sram_oe_n, sram_we_n, sram_addr},
                  {1'b0, w, !w, SRAM_AW'(exp_addr)});
      end
      stall++;
      if (stall > exp_stall + 20) break;
      @(posedge clk); #1;
    end
    check_val("stall", stall, exp_stall);
    check_val("pass", {wb_en_out, mem_r_en_out, dest_out, alu_res_out}, {wb, r, dest, addr});
    if (w) begin
      ref_mem[key] = wdata;
    end else if (r) begin
      load_known = ref_mem.exists(key);
      if (load_known) last_load = ref_mem[key];
    end
    if (r) begin
      if (load_known) begin
        check_val("mem_data", mem_data_out, last_load);
        check_val("fw_load", fw_alu_res, last_load);
      end
    end else begin
      check_val("fw_alu", fw_alu_res, addr);
    end
    if (!(r || w)) drain_rem = (drain_rem > 0) ? drain_rem - 1 : 0;
    else if (w && POSTED) drain_rem = LAT;
    else drain_rem = 0;
    $display("[TB] op %0d r=%0b w=%0b addr=%08h data=%08h stall=%0d", op_no, r, w, addr, wdata, stall);
    op_no++;
    @(posedge clk); #1;
  endtask

  // One transaction on the byte-wide instance
  task automatic op8(input bit w, input logic [31:0] addr, input logic [31:0] wdata,
                     input int exp_stall, input string tag);
    int stall;
    r8 = !w; w8 = w; alu8 = addr; val8 = wdata;
    stall = 0;
    forever begin
      @(negedge clk);
      if (ready8 === 1'b1) break;
      stall++;
      if (stall > 40) break;
      @(posedge clk); #1;
    end
    check_val(tag, stall, exp_stall);
    $display("[TB] op8 w=%0b addr=%08h data=%08h stall=%0d", w, addr, wdata, stall);
    @(posedge clk); #1;
    r8 = 1'b0; w8 = 1'b0;
  endtask

  initial begin
    int kind;
    logic [31:0] a;
    for (int i = 0; i < (1 << SRAM_AW); i++) sram_mem[i] = '0;
    for (int i = 0; i < (1 << AW8); i++) sram8_mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_pins", {mem_ready, sram_ce_n, sram_oe_n, sram_we_n, sram_addr},
              {1'b1, 1'b1, 1'b1, 1'b1, {SRAM_AW{1'b0}}});
    check_val("rst_data", mem_data_out, 32'h0);
    check_val("rst_dq_z", (sram_dq === {SRAM_DW{1'bz}}), 1'b1);
    @(posedge clk); #1;

    // Directed: word write split into two beats, read back, pass-through
    do_op(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    do_op(1'b1, 1'b0, 32'd1024, 32'h0);
    check_val("sram0", sram_mem[0], 16'hBEEF);
    check_val("sram1", sram_mem[1], 16'hDEAD);
    do_op(1'b0, 1'b0, 32'h12345678, 32'h0);
    do_op(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D);
    do_op(1'b1, 1'b0, 32'd1028, 32'h0);
    do_op(1'b1, 1'b0, 32'd1024, 32'h0);
    // Directed: address wrap below base and at the top of the SRAM
    do_op(1'b0, 1'b1, 32'(ADDR_BASE - 4), 32'hA5A55A5A);
    do_op(1'b1, 1'b0, 32'(ADDR_BASE + 4 * (KEYS - 1)), 32'h0);
    do_op(1'b1, 1'b1, 32'(ADDR_BASE + 4 * KEYS), 32'h01020304);
    do_op(1'b1, 1'b0, 32'd1024, 32'h0);

    // Random transactions
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      a = pick_addr();
      if (kind < 2)      do_op(1'b0, 1'b0, $urandom, 32'h0);
      else if (kind < 6) do_op(1'b1, 1'b0, a, 32'h0);
      else if (kind < 9) do_op(1'b0, 1'b1, a, $urandom);
      else               do_op(1'b1, 1'b1, a, $urandom);
    end

    // Reset in the second cycle of a write
    for (int i = 0; i < LAT + 1; i++) do_op(1'b0, 1'b0, $urandom, 32'h0);
    do_op(1'b1, 1'b0, 32'd1024, 32'h0);
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
    alu_res_in = 32'd1084; val_rm_in = 32'h77778888;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_w_en_in = 1'b0;
    @(negedge clk);
    check_val("abort_pins", {mem_ready, sram_ce_n, sram_we_n}, 3'b111);
    check_val("abort_dq_z", (sram_dq === {SRAM_DW{1'bz}}), 1'b1);
    check_val("abort_data", mem_data_out, 32'h0);
    ref_mem.delete(key_of(32'd1084));
    last_load = 32'h0; load_known = 1'b1; drain_rem = 0;
    $display("[TB] reset during write checked");
    @(posedge clk); #1;
    do_op(1'b0, 1'b1, 32'd1084, 32'h13572468);
    do_op(1'b1, 1'b0, 32'd1084, 32'h0);

    // Byte-wide zero-wait instance
    op8(1'b1, 32'd1024, 32'h11223344, POSTED ? 0 : 4, "stall8_wr");
    repeat (8) @(posedge clk);
    #1;
    check_val("sram8_0", sram8_mem[0], 8'h44);
    check_val("sram8_1", sram8_mem[1], 8'h33);
    check_val("sram8_2", sram8_mem[2], 8'h22);
    check_val("sram8_3", sram8_mem[3], 8'h11);
    op8(1'b0, 32'd1024, 32'h0, 4, "stall8_rd");
    check_val("data8", data8_out, 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
